mult_div_unit: RTL and testbench

Iterative multiply/divide unit: the writer side of the processor's Hi/Lo register pair. It accepts MULT/MULTU/DIV/DIVU requests from the EX stage, runs a 32-step shift-add multiply or restoring divide, and drives HiOut/LoOut straight into the Hi and Lo registers. Those registers latch their In every clock, so both outputs stay stable between operations. Busy lets hazard logic stall MFHI/MFLO until the result is valid.

---
 rtl/mult_div_unit.sv | 159 +++++++++++++++
 tb/tb_mult_div_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32-step shift-add multiplier / restoring divider feeding Hi/Lo.
// Optional MTHI/MTLO direct writes: define MULTDIV_MTHI_EN.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             WriteHi,
    input  logic             WriteLo,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic               fin;
    logic               is_div;
    logic               pneg;
    logic               rneg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] p_step;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               dz_q;

    logic               accept;
    logic               sgn;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rs;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;
    logic               div_zero;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign accept = Start && (state != RUN);
    assign sgn    = ~Op[0];
    assign a_neg  = sgn & A[WIDTH-1];
    assign b_neg  = sgn & B[WIDTH-1];

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = RUN;
            RUN:     if (fin) state_n = DONE;
            DONE:    state_n = Start ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // p holds {acc, multiplier} for multiply, {remainder, quotient} for divide
    always_comb begin
        mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]}
                 + (p[0] ? {1'b0, a_mag} : {(WIDTH+1){1'b0}});
        div_rs   = p[2*WIDTH-1:WIDTH-1];
        div_diff = div_rs - {1'b0, b_mag};
        div_ge   = div_rs >= {1'b0, b_mag};
        if (!is_div)
            p_step = {mul_sum, p[WIDTH-1:1]};
        else if (div_ge)
            p_step = {div_diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        else
            p_step = {div_rs[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        prod     = pneg ? -p : p;
        div_zero = is_div && (b_mag == '0);
        res_hi   = prod[2*WIDTH-1:WIDTH];
        res_lo   = prod[WIDTH-1:0];
        if (div_zero) begin
            // Hi returns the dividend exactly as it was issued
            res_lo = '1;
            res_hi = rneg ? -a_mag : a_mag;
        end else if (is_div) begin
            res_lo = pneg ? -p[WIDTH-1:0] : p[WIDTH-1:0];
            res_hi = rneg ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt    <= '0;
            fin    <= 1'b0;
            is_div <= 1'b0;
            pneg   <= 1'b0;
            rneg   <= 1'b0;
            a_mag  <= '0;
            b_mag  <= '0;
            p      <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            dz_q   <= 1'b0;
        end else begin
            dz_q <= 1'b0;
            if (accept) begin
                cnt    <= '0;
                fin    <= 1'b0;
                is_div <= Op[1];
                pneg   <= a_neg ^ b_neg;
                rneg   <= a_neg & Op[1];
                a_mag  <= a_neg ? -A : A;
                b_mag  <= b_neg ? -B : B;
                p      <= Op[1] ? {{WIDTH{1'b0}}, (a_neg ? -A : A)}
                                : {{WIDTH{1'b0}}, (b_neg ? -B : B)};
            end else if (state == RUN) begin
                if (!fin) begin
                    p   <= p_step;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) fin <= 1'b1;
                end else begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                    dz_q <= div_zero;
                end
            end
`ifdef MULTDIV_MTHI_EN
            else begin
                if (WriteHi) hi_q <= WriteData;
                if (WriteLo) lo_q <= WriteData;
            end
`endif
        end
    end

`ifndef MULTDIV_MTHI_EN
    logic unused_wr;
    assign unused_wr = WriteHi ^ WriteLo ^ (^WriteData);
`endif

    assign Busy    = (state == RUN);
    assign Done    = (state == DONE);
    assign DivZero = dz_q;
    assign HiOut   = hi_q;
    assign LoOut   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed/random vector table, scoreboard on Done,
// plus back-to-back, mid-run reset and Hi/Lo direct-write sequences.
module tb_mult_div_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        WriteHi;
    logic        WriteLo;
    logic [31:0] WriteData;
    logic        Busy;
    logic        Done;
    logic        DivZero;
    logic [31:0] HiOut;
    logic [31:0] LoOut;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .WriteHi(WriteHi), .WriteLo(WriteLo), .WriteData(WriteData),
        .Busy(Busy), .Done(Done), .DivZero(DivZero),
        .HiOut(HiOut), .LoOut(LoOut)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } res_t;

    vec_t vecs[$];
    res_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference built on native 64-bit and signed arithmetic
    function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] hi,
                                  output logic [31:0] lo, output logic dz);
        logic [63:0] p;
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            2'd0: begin
                p  = 64'(longint'($signed(a)) * longint'($signed(b)));
                hi = p[63:32];
                lo = p[31:0];
            end
            2'd1: begin
                p  = {32'b0, a} * {32'b0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            2'd2: begin
                if (b == 0) begin
                    dz = 1'b1; lo = '1; hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = a; hi = '0;
                end else begin
                    lo = $signed(a) / $signed(b);
                    hi = $signed(a) % $signed(b);
                end
            end
            default: begin
                if (b == 0) begin
                    dz = 1'b1; lo = '1; hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    function automatic void add(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                                logic [31:0] hi, logic [31:0] lo, logic dz);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dz = dz;
        vecs.push_back(v);
    endfunction

    always @(negedge Clk) begin
        if (Done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                res_t r;
                r = sb.pop_front();
                chk("hi", HiOut, r.hi);
                chk("lo", LoOut, r.lo);
                chk("divzero", {31'b0, DivZero}, {31'b0, r.dz});
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi,
                         input logic [31:0] lo, input logic dz);
        res_t r;
        Start = 1'b1; Op = op; A = a; B = b;
        r.hi = hi; r.lo = lo; r.dz = dz;
        sb.push_back(r);
    endtask

    // Start is dropped after the accept edge and pulsed again mid-run
    task automatic wait_done(output int k, output int busy_n);
        k = 0;
        busy_n = 0;
        do begin
            @(negedge Clk);
            k++;
            if (Busy) busy_n++;
            Start = (k == 4);
            Op = 2'($urandom);
            A = $urandom;
            B = $urandom;
        end while (!Done && k < 60);
        Start = 1'b0;
    endtask

    task automatic run_op(input vec_t v);
        int k;
        int bn;
        @(negedge Clk);
        issue(v.op, v.a, v.b, v.hi, v.lo, v.dz);
        wait_done(k, bn);
        chk("latency", k, 34);
        chk("busy_cycles", bn, 33);
        @(negedge Clk);
        chk("done_width", {31'b0, Done}, 32'd0);
        chk("dz_width", {31'b0, DivZero}, 32'd0);
        chk("hold_hi", HiOut, v.hi);
        chk("hold_lo", LoOut, v.lo);
    endtask

    initial begin
        int k;
        int bn;
        logic [31:0] hi_prev;
        logic [31:0] lo_prev;
        Reset = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
        WriteHi = 1'b0; WriteLo = 1'b0; WriteData = '0;

        add(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        add(2'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        add(2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        add(2'd3, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        add(2'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
        add(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
        add(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0);
        add(2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
        add(2'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        add(2'd1, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         1'b0);
        add(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0);
        add(2'd3, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0);
        add(2'd2, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,         1'b0);
        for (int i = 0; i < 8; i++) begin
            vec_t v;
            v.op = 2'($urandom_range(0, 3));
            v.a  = $urandom;
            v.b  = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 20);
            model(v.op, v.a, v.b, v.hi, v.lo, v.dz);
            vecs.push_back(v);
        end

        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        chk("rst_hi", HiOut, 32'd0);
        chk("rst_lo", LoOut, 32'd0);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_done", {31'b0, Done}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            Start = 1'($urandom); Op = 2'($urandom); A = $urandom; B = $urandom;
        end
        @(negedge Clk);
        Start = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("rst2_hi", HiOut, 32'd0);
        chk("rst2_lo", LoOut, 32'd0);
        chk("rst2_busy", {31'b0, Busy}, 32'd0);
        chk("rst2_done", {31'b0, Done}, 32'd0);
        chk("rst2_dz", {31'b0, DivZero}, 32'd0);

        foreach (vecs[i]) run_op(vecs[i]);

        // MULT -3*5 then DIV -7/2 issued in the Done cycle
        @(negedge Clk);
        issue(2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        wait_done(k, bn);
        chk("b2b_lat1", k, 34);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done(k, bn);
        chk("b2b_lat2", k, 34);
        chk("b2b_busy2", bn, 33);

        // Abort a MULTU 7*9 with reset at the tenth edge
        @(negedge Clk);
        Start = 1'b1; Op = 2'd1; A = 32'd7; B = 32'd9;
        repeat (9) begin
            @(negedge Clk);
            Start = 1'b0;
        end
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("abort_hi", HiOut, 32'd0);
        chk("abort_lo", LoOut, 32'd0);
        chk("abort_busy", {31'b0, Busy}, 32'd0);
        chk("abort_done", {31'b0, Done}, 32'd0);
        repeat (40) @(negedge Clk);
        chk("abort_no_done", {31'b0, Done}, 32'd0);
        begin
            vec_t v;
            v.op = 2'd3; v.a = 32'd100; v.b = 32'd7;
            v.hi = 32'd2; v.lo = 32'd14; v.dz = 1'b0;
            run_op(v);
        end

        // Direct Hi/Lo writes in IDLE and while busy
        @(negedge Clk);
        WriteHi = 1'b1; WriteData = 32'hDEAD_BEEF;
        @(negedge Clk);
        WriteHi = 1'b0;
`ifdef MULTDIV_MTHI_EN
        chk("mthi_idle", HiOut, 32'hDEAD_BEEF);
`else
        chk("mthi_idle", HiOut, 32'd2);
`endif
        chk("mthi_lo_kept", LoOut, 32'd14);
        WriteLo = 1'b1; WriteData = 32'hCAFE_F00D;
        @(negedge Clk);
        WriteLo = 1'b0;
`ifdef MULTDIV_MTHI_EN
        chk("mtlo_idle", LoOut, 32'hCAFE_F00D);
`else
        chk("mtlo_idle", LoOut, 32'd14);
`endif
        hi_prev = HiOut;
        lo_prev = LoOut;
        issue(2'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
        @(negedge Clk);
        Start = 1'b0;
        WriteHi = 1'b1; WriteLo = 1'b1; WriteData = 32'h5555_5555;
        @(negedge Clk);
        WriteHi = 1'b0; WriteLo = 1'b0;
        chk("mthi_busy", HiOut, hi_prev);
        chk("mtlo_busy", LoOut, lo_prev);
        k = 0;
        while (!Done && k < 60) begin
            @(negedge Clk);
            k++;
        end
        chk("busy_write_done", {31'b0, Done}, 32'd1);

        repeat (3) @(negedge Clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
